mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester burst arbiter that shares the single data port of the segmented data memory (sine ROM, input-pixel, output-pixel, startIO flag). Requester 0 is the vector load/store unit; requester 1 is the image I/O streamer. Grants whole bursts round-robin, generates beat addresses, registers read data back to the owner and flags illegal accesses. Sits between the CPU/IO side and the memory top.

## Interface
Parameters:
- WIDTH, 24, address/data word width of the memory port
- PIXEL, 8, pixel width; write data per beat
- MAX_BURST, 16, maximum beats per burst; LENW = $clog2(MAX_BURST+1) is derived, not overridable

Ports (N ∈ {0,1}, one set per requester):
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rN_req  in  1  burst request; held high until rN_done
- rN_we  in  1  1 = write burst, 0 = read burst
- rN_addr  in  WIDTH  burst base address
- rN_len  in  LENW  beat count
- rN_wdata  in  PIXEL  write data for current beat
- rN_beat  out  1  current beat issued this cycle; wdata consumed
- rN_rvalid  out  1  rN_rdata valid
- rN_rdata  out  WIDTH  read data, registered
- rN_done  out  1  one-cycle pulse, burst complete
- rN_err  out  1  sticky illegal-access flag
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  memory address
- mem_wd  out  WIDTH  write data, PIXEL zero-extended
- mem_rd  in  WIDTH  memory read data, combinational from mem_addr

## Operation
- States: IDLE, BURST. Reset → IDLE, priority pointer = 0.
- IDLE: if any rN_req, grant: both requesting → pointer's requester; else the single one. Latch owner, we, addr, len; go BURST. Pointer := other requester after every grant.
- Length: len = 0 treated as 1; len > MAX_BURST clamped to MAX_BURST.
- BURST: one beat per cycle; mem_addr = base + beat index (modulo 2^WIDTH); owner's rN_beat = 1; mem_we = latched we AND beat legal; mem_wd = {0, rN_wdata}.
- Read beats: mem_rd registered into rN_rdata, rN_rvalid next cycle. Write beats produce no rvalid.
- Last beat → IDLE. rN_done pulses one cycle after last beat (aligned with last rvalid on reads).
- Legality: address > STARTIO_ADDR (180302) illegal → mem_we forced 0, rdata returned 0, rN_err set. rN_err clears on next grant to that requester.
- startIO address 180302 readable by either requester; writes to it illegal.
- Non-owner outputs held 0.

## Timing
- Reset values: all outputs 0, mem_addr 0.
- req seen in IDLE at edge k → beat 0 in cycle k+1, beat i in cycle k+1+i; rvalid for beat i in cycle k+2+i.
- Occupancy: L beats + 1 IDLE cycle; back-to-back bursts separated by exactly one IDLE cycle.
- req dropped mid-burst: ignored, burst completes.
- Reset mid-burst: abort, no done, outputs 0 next cycle, pointer = 0.

## Configuration
- MEMARB_WPROT_EN defined: writes permitted only in output-pixel segment [90302, 180301]; writes elsewhere suppressed (mem_we 0) and set rN_err.
- Undefined: only the out-of-range and startIO-write checks apply; writes to ROM/input segments pass to memory.

## Structure
- Package mem_map_pkg: SEN_BASE = 0, IN_BASE = 302, OUT_BASE = 90302, SEG_SIZE = 90000, STARTIO_ADDR = 180302, enum arb_state_t {IDLE, BURST}.
- Sub-module mem_addr_check: combinational; inputs addr, we; outputs legal; contains the MEMARB_WPROT_EN conditional.

## Test plan
- r0 read, addr 302, len 4 → beats cycles 1–4, addr 302..305, rvalid cycles 2–5 with matching data, done cycle 5.
- r0 and r1 request together from reset → r0 granted first; r1 granted on the IDLE cycle after r0's last beat; third simultaneous request → r0.
- r1 write, addr 90302, len 3, wdata 0xAA,0xBB,0xCC → mem_we 1 three cycles, mem_wd 0x0000AA..0x0000CC, no rvalid, done after last beat.
- r0 read at 180301, len 3 → beat 180302 returns startIO, beat 180303 returns 0, r0_err = 1.
- With MEMARB_WPROT_EN, r0 write to addr 500 → mem_we 0, r0_err = 1; without the macro → mem_we 1, no error.
- reset asserted during beat 2 of len 8 → next cycle all outputs 0, no done; new request granted normally.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Memory map of the segmented data memory and the arbiter state type.
package mem_map_pkg;

    localparam int unsigned SEN_BASE     = 32'd0;
    localparam int unsigned IN_BASE      = 32'd302;
    localparam int unsigned OUT_BASE     = 32'd90302;
    localparam int unsigned SEG_SIZE     = 32'd90000;
    localparam int unsigned STARTIO_ADDR = 32'd180302;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side burst bundle and memory-side data port bundle of the arbiter.
interface mem_req_if #(
    parameter int WIDTH = 24,
    parameter int PIXEL = 8,
    parameter int LENW  = 5
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [LENW-1:0]  len;
    logic [PIXEL-1:0] wdata;
    logic             beat;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             done;
    logic             err;

    modport master (output req, we, addr, len, wdata,
                    input  beat, rvalid, rdata, done, err);
    modport slave  (input  req, we, addr, len, wdata,
                    output beat, rvalid, rdata, done, err);
endinterface

interface mem_bus_if #(
    parameter int WIDTH = 24
);
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    modport master (output we, addr, wd, input rd);
    modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/mem_port_arbiter_mem_addr_check.sv
// Beat legality check against the memory map.
// Define MEMARB_WPROT_EN to restrict writes to the output-pixel segment.
module mem_addr_check
    import mem_map_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] addr_i,
    input  logic             we_i,
    output logic             legal_o
);

    // Out-of-range and read-only startIO checks, optional write window.
    always_comb begin
        legal_o = 1'b1;
        if (addr_i > WIDTH'(STARTIO_ADDR)) begin
            legal_o = 1'b0;
        end else if (we_i && (addr_i == WIDTH'(STARTIO_ADDR))) begin
            legal_o = 1'b0;
`ifdef MEMARB_WPROT_EN
        end else if (we_i && ((addr_i < WIDTH'(OUT_BASE)) ||
                              (addr_i > WIDTH'(OUT_BASE + SEG_SIZE - 32'd1)))) begin
            legal_o = 1'b0;
`endif
        end else begin
            legal_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin burst arbiter for the shared data-memory port.
// Optional write protection via MEMARB_WPROT_EN (see mem_addr_check).
module mem_port_arbiter
    import mem_map_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int PIXEL     = 8,
    parameter  int MAX_BURST = 16,
    localparam int LENW      = $clog2(MAX_BURST + 1)
) (
    input  logic      clk,
    input  logic      reset,
    mem_req_if.slave  r0,
    mem_req_if.slave  r1,
    mem_bus_if.master mem
);

    arb_state_t       state_q;
    logic             ptr_q;
    logic             owner_q;
    logic             we_q;
    logic             legal_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  idx_q;
    logic [1:0]       beat_q;
    logic [1:0]       rvalid_q;
    logic [1:0]       done_q;
    logic [1:0]       err_q;
    logic [WIDTH-1:0] rdata_q [2];

    logic [1:0]       req_s;
    logic             gnt_s;
    logic             gnt_we_s;
    logic [WIDTH-1:0] gnt_addr_s;
    logic [LENW-1:0]  gnt_len_s;
    logic [WIDTH-1:0] chk_addr_s;
    logic             chk_we_s;
    logic             legal_s;

    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
        if (len == '0) begin
            return LENW'(1);
        end else if (len > LENW'(MAX_BURST)) begin
            return LENW'(MAX_BURST);
        end else begin
            return len;
        end
    endfunction

    // Grant selection and the address of the beat about to be issued.
    always_comb begin
        req_s = {r1.req, r0.req};
        if (req_s == 2'b11) begin
            gnt_s = ptr_q;
        end else begin
            gnt_s = req_s[1];
        end
        if (gnt_s) begin
            gnt_addr_s = r1.addr;
            gnt_we_s   = r1.we;
            gnt_len_s  = clamp_len(r1.len);
        end else begin
            gnt_addr_s = r0.addr;
            gnt_we_s   = r0.we;
            gnt_len_s  = clamp_len(r0.len);
        end
        if (state_q == IDLE) begin
            chk_addr_s = gnt_addr_s;
            chk_we_s   = gnt_we_s;
        end else begin
            chk_addr_s = base_q + WIDTH'(idx_q);
            chk_we_s   = we_q;
        end
    end

    mem_addr_check #(.WIDTH(WIDTH)) u_check (
        .addr_i  (chk_addr_s),
        .we_i    (chk_we_s),
        .legal_o (legal_s)
    );

    // Burst FSM; every port output except mem_wd is a register here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            legal_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            base_q     <= '0;
            mem_addr_q <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            beat_q     <= 2'b00;
            rvalid_q   <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            rvalid_q   <= 2'b00;
            done_q     <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_s) begin
                        state_q        <= BURST;
                        owner_q        <= gnt_s;
                        ptr_q          <= ~gnt_s;
                        we_q           <= gnt_we_s;
                        base_q         <= gnt_addr_s;
                        len_q          <= gnt_len_s;
                        idx_q          <= LENW'(1);
                        beat_q         <= gnt_s ? 2'b10 : 2'b01;
                        mem_addr_q     <= gnt_addr_s;
                        mem_we_q       <= gnt_we_s & legal_s;
                        legal_q        <= legal_s;
                        err_q[gnt_s]   <= ~legal_s;
                    end else begin
                        beat_q     <= 2'b00;
                        mem_addr_q <= '0;
                        mem_we_q   <= 1'b0;
                        legal_q    <= 1'b0;
                    end
                end
                BURST: begin
                    // Data of the beat on the bus this cycle returns next cycle.
                    rvalid_q[owner_q] <= ~we_q;
                    rdata_q[owner_q]  <= (legal_q && !we_q) ? mem.rd : '0;
                    if (idx_q == len_q) begin
                        state_q         <= IDLE;
                        beat_q          <= 2'b00;
                        mem_addr_q      <= '0;
                        mem_we_q        <= 1'b0;
                        legal_q         <= 1'b0;
                        done_q[owner_q] <= 1'b1;
                    end else begin
                        mem_addr_q <= chk_addr_s;
                        mem_we_q   <= we_q & legal_s;
                        legal_q    <= legal_s;
                        idx_q      <= idx_q + LENW'(1);
                        if (!legal_s) begin
                            err_q[owner_q] <= 1'b1;
                        end else begin
                            err_q[owner_q] <= err_q[owner_q];
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    beat_q   <= 2'b00;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign r0.beat   = beat_q[0];
    assign r1.beat   = beat_q[1];
    assign r0.rvalid = rvalid_q[0];
    assign r1.rvalid = rvalid_q[1];
    assign r0.rdata  = rdata_q[0];
    assign r1.rdata  = rdata_q[1];
    assign r0.done   = done_q[0];
    assign r1.done   = done_q[1];
    assign r0.err    = err_q[0];
    assign r1.err    = err_q[1];

    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    // Write data is consumed in the beat cycle itself, so it bypasses the register.
    assign mem.wd    = (|beat_q) ? WIDTH'(owner_q ? r1.wdata : r0.wdata) : '0;

endmodule
